lrn_window_engine: RTL and testbench

//  Datapath responder for the LRN address mapper. Captures GLB read data for one channel window and asserts full_flag.

---
 rtl/lrn_pkg.sv | 9 +
 rtl/lrn_div_seq.sv | 58 +++++
 rtl/lrn_window_engine.sv | 134 +++++++++++++
 tb/tb_lrn_window_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrn_pkg.sv
// lrn_pkg: engine state encoding and default widths for the LRN window engine
package lrn_pkg;
  typedef enum logic [2:0] {IDLE, FILL, DEN, DIV, OUT, WDONE} lrn_eng_state_t;
  localparam int LRN_DATA_WIDTH = 16;
  localparam int LRN_WIN_MAX    = 16;
  localparam int LRN_SQ_WIDTH   = 40;
  localparam int LRN_FRAC_BITS  = 8;
  localparam int LRN_K_CONST    = 1;
endpackage

// File: rtl/lrn_div_seq.sv
// lrn_div_seq: restoring divider, one quotient bit per cycle, saturating to OUT_WIDTH
//   core_clk, reset_n : clock, async active-low reset
//   start             : load num/den and begin (restarts any division in flight)
//   num, den          : dividend / divisor (den must be non-zero)
//   done              : one-cycle pulse, quotient valid from here until the next start
//   quotient, sat     : saturated quotient, set when the true quotient exceeds OUT_WIDTH
module lrn_div_seq import lrn_pkg::*; #(
  parameter int NUM_WIDTH = LRN_DATA_WIDTH + LRN_FRAC_BITS,
  parameter int DEN_WIDTH = LRN_SQ_WIDTH + 1,
  parameter int OUT_WIDTH = LRN_DATA_WIDTH
) (
  input  logic                 core_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] quotient,
  output logic                 sat
);
  localparam int CW = $clog2(NUM_WIDTH + 1);
  logic                 run;
  logic [CW-1:0]        cnt;
  logic [DEN_WIDTH-1:0] rem, d, diff;
  logic [NUM_WIDTH-1:0] qn;
  logic [DEN_WIDTH:0]   trial;
  logic                 ge;
  // qn shifts dividend bits out of the top while quotient bits enter at the bottom
  assign trial = {rem, qn[NUM_WIDTH-1]};
  assign ge    = trial >= {1'b0, d};
  assign diff  = trial[DEN_WIDTH-1:0] - d;
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      d   <= '0;
      qn  <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(NUM_WIDTH);
      rem <= '0;
      d   <= den;
      qn  <= num;
    end else if (run) begin
      if (cnt != '0) begin
        rem <= ge ? diff : trial[DEN_WIDTH-1:0];
        qn  <= {qn[NUM_WIDTH-2:0], ge};
        cnt <= cnt - 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end
  assign done     = run && cnt == '0;
  assign sat      = |qn[NUM_WIDTH-1:OUT_WIDTH];
  assign quotient = sat ? '1 : qn[OUT_WIDTH-1:0];
endmodule

// File: rtl/lrn_window_engine.sv
// lrn_window_engine: buffers one channel window, sums squares, normalises each sample and streams results
//   core_clk, reset_n          : clock, async active-low reset
//   start, clear               : begin layer (IDLE only) / sync abort to IDLE
//   win_len, alpha_shift       : samples per window (latched on start) / live denominator shift
//   rd_valid, rd_data          : GLB read side, accepted only in FILL
//   div_out_valid/ready/data   : result write port
//   full_flag                  : window captured, processing in progress
//   normalized_window          : one-cycle pulse after the last result of a window
//   busy, err_status           : not IDLE / sticky {saturation, overrun}
// Build option: define LRN_ERR_STATUS_EN to enable err_status detection, otherwise it reads 2'b00.
module lrn_window_engine import lrn_pkg::*; #(
  parameter int DATA_WIDTH = LRN_DATA_WIDTH,
  parameter int WIN_MAX    = LRN_WIN_MAX,
  parameter int CNT_WIDTH  = $clog2(WIN_MAX + 1),
  parameter int SQ_WIDTH   = LRN_SQ_WIDTH,
  parameter int FRAC_BITS  = LRN_FRAC_BITS,
  parameter int K_CONST    = LRN_K_CONST
) (
  input  logic                  core_clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [CNT_WIDTH-1:0]  win_len,
  input  logic [5:0]            alpha_shift,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full_flag,
  output logic                  div_out_valid,
  input  logic                  div_out_ready,
  output logic [DATA_WIDTH-1:0] div_out_data,
  output logic                  normalized_window,
  output logic                  busy,
  output logic [1:0]            err_status
);
  localparam int AW = $clog2(WIN_MAX);
  lrn_eng_state_t          state, nxt;
  logic [CNT_WIDTH-1:0]    wlen, wr_cnt, rd_cnt, len_clamp;
  logic [SQ_WIDTH-1:0]     acc;
  logic [SQ_WIDTH:0]       den, den_c, acc_sum;
  logic [2*DATA_WIDTH-1:0] sq;
  logic [DATA_WIDTH-1:0]   win_buf [WIN_MAX];
  logic [DATA_WIDTH-1:0]   div_q;
  logic                    take, hs, last_wr, last_rd;
  logic                    div_start, div_done, div_sat, div_issued, div_fin;
  assign len_clamp = win_len > CNT_WIDTH'(WIN_MAX) ? CNT_WIDTH'(WIN_MAX) : win_len;
  assign take      = state == FILL && rd_valid;
  assign hs        = state == OUT && div_out_ready;
  assign last_wr   = CNT_WIDTH'(wr_cnt + 1'b1) == wlen;
  assign last_rd   = CNT_WIDTH'(rd_cnt + 1'b1) == wlen;
  assign sq        = (2*DATA_WIDTH)'(rd_data) * (2*DATA_WIDTH)'(rd_data);
  assign acc_sum   = {1'b0, acc} + (SQ_WIDTH+1)'(sq);
  assign den_c     = (SQ_WIDTH+1)'(K_CONST) + (SQ_WIDTH+1)'(acc >> alpha_shift);
  // a division started before a clear may still finish; only a done we asked for counts
  assign div_start = state == DIV && !div_issued;
  assign div_fin   = div_done && div_issued;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start && win_len != '0 ? FILL : IDLE;
      FILL:    nxt = take && last_wr ? DEN : FILL;
      DEN:     nxt = DIV;
      DIV:     nxt = div_fin ? OUT : DIV;
      OUT:     nxt = div_out_ready ? (last_rd ? WDONE : DIV) : OUT;
      WDONE:   nxt = FILL;
      default: nxt = IDLE;
    endcase
    if (clear) nxt = IDLE;
  end
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wlen       <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      acc        <= '0;
      den        <= '0;
      full_flag  <= 1'b0;
      div_issued <= 1'b0;
    end else begin
      state      <= nxt;
      div_issued <= !clear && (div_start || (div_issued && !div_done));
      if (clear || state == WDONE) begin
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        acc       <= '0;
        full_flag <= 1'b0;
      end else begin
        if (state == IDLE && start) wlen <= len_clamp;
        if (take) begin
          wr_cnt <= wr_cnt + 1'b1;
          acc    <= acc_sum[SQ_WIDTH] ? '1 : acc_sum[SQ_WIDTH-1:0];
        end
        if (take && last_wr) full_flag <= 1'b1;
        if (state == DEN) den <= den_c;
        if (hs) rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end
  // window contents are only meaningful between FILL and WDONE, so no reset is needed
  always_ff @(posedge core_clk) begin
    if (take) win_buf[wr_cnt[AW-1:0]] <= rd_data;
  end
  lrn_div_seq #(
    .NUM_WIDTH(DATA_WIDTH + FRAC_BITS),
    .DEN_WIDTH(SQ_WIDTH + 1),
    .OUT_WIDTH(DATA_WIDTH)
  ) u_div (
    .core_clk (core_clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .num      ({win_buf[rd_cnt[AW-1:0]], {FRAC_BITS{1'b0}}}),
    .den      (den),
    .done     (div_done),
    .quotient (div_q),
    .sat      (div_sat)
  );
  assign busy              = state != IDLE;
  assign div_out_valid     = state == OUT;
  assign div_out_data      = div_out_valid ? div_q : '0;
  assign normalized_window = state == WDONE;
`ifdef LRN_ERR_STATUS_EN
  logic [1:0] err;
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) err <= 2'b00;
    else if (clear || (state == IDLE && start)) err <= 2'b00;
    else err <= err | {(take && acc_sum[SQ_WIDTH]) || (div_fin && div_sat), rd_valid && state != FILL};
  end
  assign err_status = err;
`else
  logic unused_sat;
  assign unused_sat = div_sat;
  assign err_status = 2'b00;
`endif
endmodule

// File: tb/tb_lrn_window_engine.sv
// tb_lrn_window_engine: randomized windows checked against an arithmetic reference of the LRN normalisation
module tb_lrn_window_engine;
  logic        core_clk = 1'b0;
  logic        reset_n, start, clear, rd_valid, div_out_ready;
  logic [4:0]  win_len;
  logic [5:0]  alpha_shift;
  logic [15:0] rd_data, div_out_data;
  logic        full_flag, div_out_valid, normalized_window, busy;
  logic [1:0]  err_status;
  int vectors = 0, miscompares = 0, hs_cnt = 0, norm_cnt = 0;
  longint unsigned exp_q[$];
  int unsigned smp[16];
  bit hold_low = 1'b0, rnd_ready = 1'b0, stall_prev = 1'b0;
  logic [15:0] prev_data;
`ifdef LRN_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  lrn_window_engine dut (
    .core_clk          (core_clk),
    .reset_n           (reset_n),
    .start             (start),
    .clear             (clear),
    .win_len           (win_len),
    .alpha_shift       (alpha_shift),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .full_flag         (full_flag),
    .div_out_valid     (div_out_valid),
    .div_out_ready     (div_out_ready),
    .div_out_data      (div_out_data),
    .normalized_window (normalized_window),
    .busy              (busy),
    .err_status        (err_status)
  );
  always #5 core_clk = ~core_clk;
  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask
  // reference: den = 1 + (sum of squares >> shift); q = min((x*256)/den, 65535)
  task automatic model(input int n, input int sh);
    longint unsigned sum = 0, den, q;
    for (int i = 0; i < n; i++) sum += 64'(smp[i]) * 64'(smp[i]);
    if (sum > 64'hFF_FFFF_FFFF) sum = 64'hFF_FFFF_FFFF;
    den = 1 + ((sh >= 40) ? 64'd0 : (sum >> sh));
    for (int i = 0; i < n; i++) begin
      q = (64'(smp[i]) << 8) / den;
      exp_q.push_back(q > 65535 ? 64'd65535 : q);
    end
  endtask
  task automatic rand_smp(input int n);
    for (int i = 0; i < n; i++) smp[i] = $urandom_range(0, 65535);
  endtask
  task automatic do_start(input int len, input int sh);
    win_len = 5'(len);
    alpha_shift = 6'(sh);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic feed(input int n, input bit gaps, input bit fill_done);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        rd_valid = 1'b0;
        rd_data = 16'($urandom);
        tick();
      end
      rd_valid = 1'b1;
      rd_data = 16'(smp[i]);
      tick();
    end
    rd_valid = 1'b0;
    if (fill_done) chk("full_flag_set", full_flag, 1);
  endtask
  task automatic finish_window(input int h0, input int n);
    int n0 = norm_cnt;
    int c = 0;
    while (norm_cnt == n0 && c < 3000) begin
      tick();
      c++;
    end
    chk("norm_pulse", norm_cnt - n0, 1);
    chk("handshakes", hs_cnt - h0, n);
    chk("full_flag_clr", full_flag, 0);
  endtask
  task automatic abort();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_busy", busy, 0);
    chk("clear_full", full_flag, 0);
    chk("clear_valid", div_out_valid, 0);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_full"}, full_flag, 0);
    chk({nm, "_valid"}, div_out_valid, 0);
    chk({nm, "_data"}, div_out_data, 0);
    chk({nm, "_norm"}, normalized_window, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err_status, 0);
  endtask
  initial begin
    div_out_ready = 1'b0;
    forever begin
      @(posedge core_clk);
      #1;
      div_out_ready = hold_low ? 1'b0 : rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial forever begin
    @(negedge core_clk);
    if (!reset_n) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("hold_valid", div_out_valid, 1);
        chk("hold_data", div_out_data, prev_data);
      end
      if (div_out_valid && div_out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_result: got %0d, expected no result", div_out_data);
        end else chk("result", div_out_data, exp_q.pop_front());
      end
      if (normalized_window) begin
        norm_cnt++;
        chk("window_drained", exp_q.size(), 0);
      end
      stall_prev = div_out_valid && !div_out_ready;
      prev_data = div_out_data;
    end
  end
  initial begin
    int h0, c, sh, len;
    logic [15:0] d;
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; rd_valid = 1'b0; rd_data = '0;
    win_len = '0; alpha_shift = '0;
    repeat (3) tick();
    chk_zero("reset");
    reset_n = 1'b1;
    tick();
    smp[0] = 2; smp[1] = 4; smp[2] = 6; smp[3] = 8;
    exp_q = {4, 8, 12, 16};
    h0 = hs_cnt;
    do_start(4, 0);
    chk("start_busy", busy, 1);
    feed(4, 0, 1);
    finish_window(h0, 4);
    abort();
    smp[0] = 16'hFFFF;
    exp_q = {65535};
    h0 = hs_cnt;
    do_start(1, 40);
    feed(1, 0, 1);
    finish_window(h0, 1);
    chk("err_sat", err_status, ERR_EN ? 2 : 0);
    abort();
    rand_smp(4);
    sh = $urandom_range(0, 12);
    model(4, sh);
    hold_low = 1'b1;
    h0 = hs_cnt;
    do_start(4, sh);
    feed(4, 1, 1);
    c = 0;
    while (!div_out_valid && c < 200) begin
      tick();
      c++;
    end
    chk("valid_wait", div_out_valid, 1);
    d = div_out_data;
    for (int i = 0; i < 5; i++) begin
      rd_valid = (i == 2);
      rd_data = 16'($urandom);
      tick();
      rd_valid = 1'b0;
      chk("bp_valid", div_out_valid, 1);
      chk("bp_data", div_out_data, d);
    end
    chk("err_overrun", err_status[0], ERR_EN);
    hold_low = 1'b0;
    finish_window(h0, 4);
    abort();
    smp[0] = 1; smp[1] = 1; smp[2] = 1;
    exp_q = {64, 64, 64};
    h0 = hs_cnt;
    do_start(3, 0);
    feed(3, 1, 1);
    finish_window(h0, 3);
    smp[0] = 3; smp[1] = 3; smp[2] = 3;
    exp_q = {27, 27, 27};
    h0 = hs_cnt;
    feed(3, 1, 1);
    finish_window(h0, 3);
    abort();
    rnd_ready = 1'b1;
    rand_smp(4);
    model(4, 2);
    h0 = hs_cnt;
    do_start(4, 2);
    feed(4, 0, 1);
    c = 0;
    while (hs_cnt == h0 && c < 200) begin
      tick();
      c++;
    end
    chk("first_handshake", hs_cnt - h0, 1);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1 chk_zero("mid_reset");
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    rand_smp(4);
    model(4, 5);
    h0 = hs_cnt;
    do_start(4, 5);
    feed(4, 1, 1);
    finish_window(h0, 4);
    abort();
    do_start(0, 0);
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_busy_later", busy, 0);
    rand_smp(4);
    do_start(4, 0);
    feed(2, 0, 0);
    chk("fill_busy", busy, 1);
    chk("fill_not_full", full_flag, 0);
    abort();
    rand_smp(4);
    model(4, 3);
    h0 = hs_cnt;
    do_start(4, 3);
    feed(4, 1, 1);
    finish_window(h0, 4);
    abort();
    rand_smp(16);
    sh = $urandom_range(0, 45);
    model(16, sh);
    h0 = hs_cnt;
    do_start(20, sh);
    feed(16, 1, 1);
    finish_window(h0, 16);
    abort();
    for (int w = 0; w < 6; w++) begin
      len = $urandom_range(1, 16);
      sh = $urandom_range(0, 45);
      rand_smp(len);
      model(len, sh);
      h0 = hs_cnt;
      do_start(len, sh);
      feed(len, 1, 1);
      finish_window(h0, len);
      abort();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
